mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (data load/store).
- Data port has fixed priority. A starvation counter guarantees forward progress for fetch.
- One access is outstanding at a time, with a fixed memory latency.
- Per-port acks let pipeline control derive stall_IF / stall_MEM as req & ~ack.

---
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access.
// Data has fixed priority; a starvation counter forces a fetch grant after
// STARVE_MAX consecutive data wins over a pending fetch. One access is in
// flight at a time: IDLE (arbitrate) -> ACCESS (MEM_LAT cycles) -> DONE (ack).
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD   = CW'(MEM_LAT - 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   starve_cnt;
  logic            grant_d;
  logic            pick_d;

  // Arbitration decision: data wins unless fetch has been starved long enough.
  always_comb begin
    pick_d = d_req && !(if_req && (starve_cnt == STARVE_TOP));
  end

  // Access sequencer: grant in IDLE, hold the memory request for MEM_LAT
  // cycles, then pulse the winner's ack for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      starve_cnt <= '0;
      grant_d    <= 1'b0;
      if_rdata   <= '0;
      if_ack     <= 1'b0;
      d_rdata    <= '0;
      d_ack      <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            state   <= ACCESS;
            busy    <= 1'b1;
            mem_en  <= 1'b1;
            cnt     <= CNT_LOAD;
            grant_d <= pick_d;
            if (pick_d) begin
              mem_addr  <= d_addr;
              mem_we    <= d_we;
              mem_wdata <= d_wdata;
              if (if_req && (starve_cnt != STARVE_TOP))
                starve_cnt <= starve_cnt + 1'b1;
            end else begin
              mem_addr   <= if_addr;
              mem_we     <= 1'b0;
              mem_wdata  <= '0;
              starve_cnt <= '0;
            end
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            state  <= DONE;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (grant_d) begin
              d_ack <= 1'b1;
              if (!mem_we)
                d_rdata <= mem_rdata;
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy   <= 1'b0;
          if_ack <= 1'b0;
          d_ack  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: two instances (MEM_LAT=2 and MEM_LAT=1)
// checked every cycle against a timeline model, plus hand-computed pins.
module tb_mem_port_arbiter;

  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req    [2];
  logic [31:0] if_addr   [2];
  logic [31:0] if_rdata  [2];
  logic        if_ack    [2];
  logic        d_req     [2];
  logic        d_we      [2];
  logic [31:0] d_addr    [2];
  logic [31:0] d_wdata   [2];
  logic [31:0] d_rdata   [2];
  logic        d_ack     [2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic        busy      [2];

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(2), .STARVE_MAX(SMAX)) u0 (
    .clk(clk), .rst(rst),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_rdata(if_rdata[0]), .if_ack(if_ack[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_rdata(d_rdata[0]), .d_ack(d_ack[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0])
  );

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(SMAX)) u1 (
    .clk(clk), .rst(rst),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_rdata(if_rdata[1]), .if_ack(if_ack[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_rdata(d_rdata[1]), .d_ack(d_ack[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1])
  );

  // Model: m_k = cycles elapsed since the grant cycle (-1 when idle).
  int          m_k      [2];
  bit          m_wd     [2];
  logic [31:0] m_a      [2];
  bit          m_we     [2];
  logic [31:0] m_wdat   [2];
  int          m_starve [2];
  logic [31:0] m_rif    [2];
  logic [31:0] m_rd     [2];

  int vectors     = 0;
  int miscompares = 0;
  bit check_en    = 1'b0;
  int cyc         = 0;

  function automatic int lat(int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic logic [31:0] mem_val(logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  task automatic chk(string name, int inst, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d cycle %0d: got %h expected %h", name, inst, cyc, act, exp);
    end
  endtask

  task automatic model_step(int i);
    int L;
    L = lat(i);
    if (rst) begin
      m_k[i] = -1; m_wd[i] = 1'b0; m_a[i] = '0; m_we[i] = 1'b0; m_wdat[i] = '0;
      m_starve[i] = 0; m_rif[i] = '0; m_rd[i] = '0;
    end else if (m_k[i] < 0) begin
      if (if_req[i] || d_req[i]) begin
        m_wd[i] = d_req[i] && !(if_req[i] && m_starve[i] == SMAX);
        if (m_wd[i]) begin
          m_a[i] = d_addr[i]; m_we[i] = d_we[i]; m_wdat[i] = d_wdata[i];
          if (if_req[i] && m_starve[i] < SMAX) m_starve[i]++;
        end else begin
          m_a[i] = if_addr[i]; m_we[i] = 1'b0; m_wdat[i] = '0; m_starve[i] = 0;
        end
        m_k[i] = 1;
      end
    end else begin
      m_k[i]++;
      if (m_k[i] == L + 1) begin
        if (!m_wd[i]) m_rif[i] = mem_val(m_a[i]);
        else if (!m_we[i]) m_rd[i] = mem_val(m_a[i]);
      end else if (m_k[i] == L + 2) begin
        m_k[i] = -1;
      end
    end
  endtask

  // One clock: DUT and model advance on the edge, memory data for the new
  // cycle is driven, then return shortly after the falling edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) model_step(i);
    #1;
    for (int i = 0; i < 2; i++)
      mem_rdata[i] = (m_k[i] == lat(i)) ? mem_val(m_a[i]) : (32'hBAD00000 | 32'(cyc));
    @(negedge clk);
    #1;
  endtask

  // Every-cycle comparison of both instances against the model.
  initial begin
    int  k, L;
    bit  acc, ack;
    forever begin
      @(negedge clk);
      if (check_en) begin
        for (int i = 0; i < 2; i++) begin
          k   = m_k[i];
          L   = lat(i);
          acc = (k >= 1) && (k <= L);
          ack = (k == L + 1);
          chk("busy",      i, 32'(busy[i]),   32'(k >= 1));
          chk("mem_en",    i, 32'(mem_en[i]), 32'(acc));
          chk("mem_we",    i, 32'(mem_we[i]), 32'(acc && m_we[i]));
          chk("mem_addr",  i, mem_addr[i],    m_a[i]);
          chk("mem_wdata", i, mem_wdata[i],   m_wdat[i]);
          chk("if_ack",    i, 32'(if_ack[i]), 32'(ack && !m_wd[i]));
          chk("d_ack",     i, 32'(d_ack[i]),  32'(ack && m_wd[i]));
          chk("if_rdata",  i, if_rdata[i],    m_rif[i]);
          chk("d_rdata",   i, d_rdata[i],     m_rd[i]);
          chk("ack_excl",  i, 32'(if_ack[i] && d_ack[i]), 32'd0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout inst0 cycle %0d: got timeout expected finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0] pat;
    int         nack, last, start, j;
    bit         seen;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if_req[i] = 1'b0; if_addr[i] = '0; d_req[i] = 1'b0; d_we[i] = 1'b0;
      d_addr[i] = '0; d_wdata[i] = '0; mem_rdata[i] = '0;
      m_k[i] = -1;
    end
    tick();
    check_en = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_busy",   0, 32'(busy[0]),   32'd0);
    chk("rst_mem_en", 1, 32'(mem_en[1]), 32'd0);

    // Single fetch, MEM_LAT=2
    if_req[0] = 1'b1; if_addr[0] = 32'h10;
    tick();
    chk("t1_en_c1",   0, 32'(mem_en[0]), 32'd1);
    chk("t1_addr_c1", 0, mem_addr[0],    32'h10);
    tick();
    chk("t1_en_c2",   0, 32'(mem_en[0]), 32'd1);
    tick();
    chk("t1_ack",     0, 32'(if_ack[0]), 32'd1);
    chk("t1_rdata",   0, if_rdata[0],    32'hDEADBEEF);
    chk("t1_busy_c3", 0, 32'(busy[0]),   32'd1);
    if_req[0] = 1'b0;
    tick();
    chk("t1_idle", 0, 32'(busy[0]), 32'd0);

    // Load from 0x80, then a store to 0x40 whose inputs change after grant
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h80;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      tick();
      seen = d_ack[0];
    end
    chk("t2_load_ack", 0, 32'(seen), 32'd1);
    d_req[0] = 1'b0;
    tick();
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h40; d_wdata[0] = 32'h12345678;
    tick();
    chk("t2_we_c1", 0, 32'(mem_we[0]), 32'd1);
    d_addr[0] = 32'hFFFFFFF0; d_wdata[0] = 32'h0;
    tick();
    chk("t2_we_c2",    0, 32'(mem_we[0]), 32'd1);
    chk("t2_addr_c2",  0, mem_addr[0],    32'h40);
    chk("t2_wdata_c2", 0, mem_wdata[0],   32'h12345678);
    tick();
    chk("t2_ack",    0, 32'(d_ack[0]),  32'd1);
    chk("t2_we_c3",  0, 32'(mem_we[0]), 32'd0);
    chk("t2_rdata",  0, d_rdata[0],     mem_val(32'h80));
    d_req[0] = 1'b0; d_we[0] = 1'b0;
    tick();

    // Both ports requesting continuously: D,D,D,D,IF,D,D,D,D,IF
    if_req[0] = 1'b1; if_addr[0] = 32'h100;
    d_req[0]  = 1'b1; d_addr[0]  = 32'h200;
    pat = '0; nack = 0; last = -1;
    for (int n = 0; n < 60 && nack < 10; n++) begin
      tick();
      if (if_ack[0] || d_ack[0]) begin
        pat[nack] = if_ack[0];
        if (last >= 0) chk("t3_spacing", 0, 32'(cyc - last), 32'd4);
        last = cyc;
        nack++;
      end
    end
    chk("t3_count", 0, 32'(nack), 32'd10);
    chk("t3_order", 0, 32'(pat),  32'h210);
    if_req[0] = 1'b0; d_req[0] = 1'b0;
    tick();

    // Reset during the second ACCESS cycle, then a fresh access
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h300;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_no_ack",   0, 32'(d_ack[0]),  32'd0);
    chk("t4_busy",     0, 32'(busy[0]),   32'd0);
    chk("t4_mem_addr", 0, mem_addr[0],    32'd0);
    chk("t4_d_rdata",  0, d_rdata[0],     32'd0);
    tick();
    chk("t4_ack_early1", 0, 32'(d_ack[0]), 32'd0);
    tick();
    chk("t4_ack_early2", 0, 32'(d_ack[0]), 32'd0);
    tick();
    chk("t4_ack",   0, 32'(d_ack[0]), 32'd1);
    chk("t4_rdata", 0, d_rdata[0],    mem_val(32'h300));
    d_req[0] = 1'b0;
    tick();

    // MEM_LAT=1: three queued loads, acks at cycles 2, 5, 8
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h500;
    start = cyc; j = 0;
    for (int n = 0; n < 20 && j < 3; n++) begin
      tick();
      if (d_ack[1]) begin
        chk("t5_ack_cycle", 1, 32'(cyc - start), 32'(2 + 3 * j));
        chk("t5_rdata",     1, d_rdata[1],       mem_val(32'h500 + 32'(4 * j)));
        j++;
        d_addr[1] = 32'h500 + 32'(4 * j);
      end
    end
    chk("t5_count", 1, 32'(j), 32'd3);
    d_req[1] = 1'b0;
    tick();

    // Fetch request withdrawn mid-access still completes
    if_req[1] = 1'b1; if_addr[1] = 32'h600;
    tick();
    if_req[1] = 1'b0;
    tick();
    chk("t6_ack",   1, 32'(if_ack[1]), 32'd1);
    chk("t6_rdata", 1, if_rdata[1],    mem_val(32'h600));
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
